coproc_cmd_ctrl: RTL and testbench
==================================

Name: coproc_cmd_ctrl

Overview:
- Command/handshake controller directly downstream of the HPS PIO bridge.
- Consumes the 32-bit instruction word and start level driven by HPS software.
- Writes pixels into the image buffer, or launches the scaling algorithm engine.
- Returns done/donewrite levels to the PIO inputs under a 4-phase handshake.

Parameters:
ADDR_W, 15, image buffer address width
IMG_PIXELS, 19200, valid pixel count; addresses >= this are out of range
TIMEOUT_CYCLES, 1000000, RUN watchdog limit in cycles; 0 disables the watchdog

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  asynchronous active-low reset
instruct  in  32  instruction word from the PIO
start  in  1  start level from the PIO
done  out  1  NOP/RUN/CLRSTAT/invalid-opcode completion level to the PIO
donewrite  out  1  STORE completion level to the PIO
busy  out  1  high whenever state != IDLE
mem_we  out  1  image buffer write enable, one-cycle pulse
mem_addr  out  ADDR_W  image buffer write address
mem_wdata  out  8  pixel data
alg_start  out  1  algorithm engine launch, one-cycle pulse
alg_sel  out  3  algorithm select
alg_done  in  1  algorithm engine completion pulse
alg_timeout  out  1  sticky watchdog flag
cycles_last  out  32  cycle count of the last RUN

Behaviour:
- Clock and reset: one clock, clk_clk. Reset is asynchronous, active-low (reset_reset_n).
- Reset values: all outputs 0; state IDLE; start_prev 0.
- Instruction fields:
  - [2:0] opcode: 000 NOP, 001 STORE, 010 RUN, 011 CLRSTAT; 1xx invalid, treated as NOP.
  - STORE: [17:3] address, [25:18] pixel.
  - RUN: [5:3] alg_sel.
  - [31:26] reserved, ignored.
- Start detection: start_prev registers start every cycle. A rising edge (start=1, start_prev=0) is recognised only in IDLE; outside IDLE it is ignored.
- FSM:
  - IDLE: on rising edge at edge N, latch instruct into instr_reg and go to DECODE.
  - DECODE (edge N+1):
    - STORE, in range: mem_addr/mem_wdata loaded, mem_we<=1, go to WRITE.
    - STORE, out of range: no write, go to WRITE with mem_we held 0.
    - RUN: alg_sel loaded, alg_start<=1, counter<=1, go to RUN_WAIT.
    - CLRSTAT: clear alg_timeout and cycles_last, done<=1, go to ACK.
    - NOP/invalid: done<=1, go to ACK.
  - WRITE (edge N+2): mem_we<=0, donewrite<=1, go to ACK. donewrite is visible 2 cycles after the start edge is sampled.
  - RUN_WAIT:
    - alg_start<=0 after one cycle; counter increments each cycle, saturating at 2^32-1.
    - On the edge alg_done is sampled 1: cycles_last<=counter, done<=1, go to ACK.
    - If TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES first: alg_timeout<=1, cycles_last<=counter, done<=1, go to ACK.
    - If alg_done and timeout occur in the same cycle, alg_done wins; no timeout flag.
  - ACK: hold done/donewrite while start=1. When start sampled 0, clear both and go to IDLE. Minimum ACK duration is 1 cycle.
- alg_done outside RUN_WAIT is ignored.
- start falling before ACK: the command still completes. Flags assert for one cycle in ACK, then the FSM returns to IDLE.
- mem_addr, mem_wdata and alg_sel hold their last values when not in use.
- Reset mid-operation: immediate return to reset values. No further mem_we or alg_start pulse occurs.

Optional Feature:
- Macro: COPROC_START_SYNC_EN.
- Defined: start passes through a 2-flop synchroniser before edge detection; all start-related latencies grow by 2 cycles; ACK exit uses the synchronised start.
- Undefined: start is used directly (same clock domain as the PIO).

Test Plan:
1. Reset with all inputs 0 -> every output 0, busy 0.
2. instruct=STORE addr 0x0005 pixel 0xA7 (0x029C_0029), start 0->1 -> mem_we one cycle with mem_addr=5, mem_wdata=0xA7; donewrite=1 two cycles after the edge; held until start=0, then 0 one cycle later.
3. STORE addr 19200 -> no mem_we pulse; donewrite still asserts.
4. RUN alg_sel=3 (0x0000_001A); alg_done pulsed 10 cycles after alg_start -> alg_start one cycle with alg_sel=3; done=1 on the alg_done edge; cycles_last=10; alg_timeout=0.
5. TIMEOUT_CYCLES=50, RUN with alg_done never asserted -> done and alg_timeout=1 at count 50. A following CLRSTAT clears alg_timeout and cycles_last and asserts done.
6. Reset asserted during RUN_WAIT, then a second start edge while in ACK -> reset: all outputs 0 immediately; second edge ignored; opcode 111 yields done only.

Source files
------------

// File: rtl/coproc_cmd_ctrl.sv
// Command/handshake controller between the HPS PIO bridge, the image buffer and the scaling engine.
// Optional build macro COPROC_START_SYNC_EN adds a 2-flop synchroniser on the start level.
module coproc_cmd_ctrl #(
  parameter int unsigned ADDR_W         = 15,
  parameter int unsigned IMG_PIXELS     = 19200,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [31:0]       instruct,
  input  logic              start,
  output logic              done,
  output logic              donewrite,
  output logic              busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              alg_start,
  output logic [2:0]        alg_sel,
  input  logic              alg_done,
  output logic              alg_timeout,
  output logic [31:0]       cycles_last
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WRITE,
    S_RUN_WAIT,
    S_ACK
  } state_e;

  localparam logic [2:0]  OP_STORE   = 3'b001;
  localparam logic [2:0]  OP_RUN     = 3'b010;
  localparam logic [2:0]  OP_CLRSTAT = 3'b011;
  localparam logic [31:0] PIX_LIMIT  = 32'(IMG_PIXELS);
  localparam logic [31:0] TMO_LIMIT  = 32'(TIMEOUT_CYCLES);
  localparam logic        TMO_EN     = (TIMEOUT_CYCLES != 0);

  state_e      state_q;
  logic [25:0] instr_q;
  logic [31:0] counter_q;
  logic        start_prev_q;
  logic        start_int;
  logic        start_rise_c;

  // Reserved instruction bits carry no meaning for this block.
  logic unused_rsvd;
  assign unused_rsvd = ^instruct[31:26];

`ifdef COPROC_START_SYNC_EN
  logic start_s1_q;
  logic start_s2_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      start_s1_q <= 1'b0;
      start_s2_q <= 1'b0;
    end else begin
      start_s1_q <= start;
      start_s2_q <= start_s1_q;
    end
  end

  assign start_int = start_s2_q;
`else
  assign start_int = start;
`endif

  assign start_rise_c = start_int & ~start_prev_q;

  logic [2:0]  opcode;
  logic [14:0] st_addr;
  logic [7:0]  st_pix;
  logic [2:0]  run_sel;
  logic        addr_ok;

  assign opcode  = instr_q[2:0];
  assign st_addr = instr_q[17:3];
  assign st_pix  = instr_q[25:18];
  assign run_sel = instr_q[5:3];
  assign addr_ok = ({17'd0, st_addr} < PIX_LIMIT);

  // Command FSM; every output is a register updated on the transition that produces it.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q      <= S_IDLE;
      instr_q      <= '0;
      counter_q    <= '0;
      start_prev_q <= 1'b0;
      done         <= 1'b0;
      donewrite    <= 1'b0;
      busy         <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      alg_start    <= 1'b0;
      alg_sel      <= '0;
      alg_timeout  <= 1'b0;
      cycles_last  <= '0;
    end else begin
      start_prev_q <= start_int;
      case (state_q)
        S_IDLE: begin
          if (start_rise_c) begin
            instr_q <= instruct[25:0];
            busy    <= 1'b1;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_STORE: begin
              if (addr_ok) begin
                mem_addr  <= ADDR_W'(st_addr);
                mem_wdata <= st_pix;
                mem_we    <= 1'b1;
              end
              state_q <= S_WRITE;
            end
            OP_RUN: begin
              alg_sel   <= run_sel;
              alg_start <= 1'b1;
              counter_q <= 32'd1;
              state_q   <= S_RUN_WAIT;
            end
            OP_CLRSTAT: begin
              alg_timeout <= 1'b0;
              cycles_last <= '0;
              done        <= 1'b1;
              state_q     <= S_ACK;
            end
            default: begin
              done    <= 1'b1;
              state_q <= S_ACK;
            end
          endcase
        end
        S_WRITE: begin
          mem_we    <= 1'b0;
          donewrite <= 1'b1;
          state_q   <= S_ACK;
        end
        S_RUN_WAIT: begin
          alg_start <= 1'b0;
          // alg_done takes priority over a watchdog expiry in the same cycle.
          if (alg_done) begin
            cycles_last <= counter_q;
            done        <= 1'b1;
            state_q     <= S_ACK;
          end else if (TMO_EN && (counter_q == TMO_LIMIT)) begin
            alg_timeout <= 1'b1;
            cycles_last <= counter_q;
            done        <= 1'b1;
            state_q     <= S_ACK;
          end else if (counter_q != '1) begin
            counter_q <= counter_q + 32'd1;
          end
        end
        S_ACK: begin
          if (!start_int) begin
            done      <= 1'b0;
            donewrite <= 1'b0;
            busy      <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coproc_cmd_ctrl.sv
// Scoreboard bench for coproc_cmd_ctrl: directed commands push expected events, a monitor pops and compares.
module tb_coproc_cmd_ctrl;

  localparam int unsigned ADDR_W = 15;
  localparam int EV_WE   = 0;
  localparam int EV_ALG  = 1;
  localparam int EV_DONE = 2;
  localparam int EV_DW   = 3;

  typedef struct {
    int          kind;
    logic [31:0] v1;
    logic [31:0] v2;
  } ev_t;

  logic              clk = 1'b0;
  logic              reset_reset_n;
  logic [31:0]       instruct;
  logic              start;
  logic              done;
  logic              donewrite;
  logic              busy;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              alg_start;
  logic [2:0]        alg_sel;
  logic              alg_done;
  logic              alg_timeout;
  logic [31:0]       cycles_last;

  int  n_total  = 0;
  int  n_passed = 0;
  ev_t exp_q[$];

  coproc_cmd_ctrl #(
    .ADDR_W(15),
    .IMG_PIXELS(19200),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(reset_reset_n),
    .instruct     (instruct),
    .start        (start),
    .done         (done),
    .donewrite    (donewrite),
    .busy         (busy),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .alg_start    (alg_start),
    .alg_sel      (alg_sel),
    .alg_done     (alg_done),
    .alg_timeout  (alg_timeout),
    .cycles_last  (cycles_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input int kind, input logic [31:0] v1, input logic [31:0] v2);
    ev_t e;
    e.kind = kind;
    e.v1   = v1;
    e.v2   = v2;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input logic [31:0] v1, input logic [31:0] v2);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("sb_unexpected_event", 32'(kind), 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check("sb_kind", 32'(kind), 32'(e.kind));
      check("sb_v1", v1, e.v1);
      check("sb_v2", v2, e.v2);
    end
  endtask

  // Monitor: turns DUT output activity into events and scores them against the queue.
  logic done_prev = 1'b0;
  logic dw_prev   = 1'b0;
  always @(negedge clk) begin
    if (reset_reset_n) begin
      if (mem_we)               observe(EV_WE, 32'(mem_addr), 32'(mem_wdata));
      if (alg_start)            observe(EV_ALG, 32'(alg_sel), 32'd0);
      if (done && !done_prev)   observe(EV_DONE, 32'(alg_timeout), cycles_last);
      if (donewrite && !dw_prev) observe(EV_DW, 32'd0, 32'd0);
    end
    done_prev = done;
    dw_prev   = donewrite;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr);
    instruct = instr;
    start    = 1'b1;
    tick();
  endtask

  task automatic finish_cmd(input string name, input int hold);
    int n;
    n = 0;
    while (!(done || donewrite) && n < 200) begin
      tick();
      n++;
    end
    check({name, "_flag"}, 32'(done | donewrite), 32'd1);
    repeat (hold) tick();
    check({name, "_held"}, 32'(done | donewrite), 32'd1);
    start = 1'b0;
    tick();
    check({name, "_clr"}, 32'({busy, done, donewrite}), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, 32'({done, donewrite, busy, mem_we, alg_start, alg_timeout}), 32'd0);
    check({name, "_cyc"}, cycles_last, 32'd0);
    check({name, "_data"}, 32'({mem_addr, mem_wdata, alg_sel}), 32'd0);
  endtask

  function automatic logic [31:0] store_w(input logic [14:0] addr, input logic [7:0] pix);
    return {6'd0, pix, addr, 3'b001};
  endfunction

  function automatic logic [31:0] run_w(input logic [2:0] sel);
    return {26'd0, sel, 3'b010};
  endfunction

  initial begin
    reset_reset_n = 1'b1;
    instruct      = '0;
    start         = 1'b0;
    alg_done      = 1'b0;
    #2 reset_reset_n = 1'b0;
    repeat (2) tick();
    check_all_zero("reset");
    reset_reset_n = 1'b1;
    tick();

    // STORE addr 5 pixel 0xA7 with exact handshake timing.
    push(EV_WE, 32'd5, 32'hA7);
    push(EV_DW, 32'd0, 32'd0);
    check("store_word", store_w(15'd5, 8'hA7), 32'h029C_0029);
    issue(32'h029C_0029);
    check("st_busy", 32'(busy), 32'd1);
    tick();
    check("st_we_n1", 32'({mem_we, donewrite}), 32'b10);
    tick();
    check("st_dw_n2", 32'({mem_we, donewrite}), 32'b01);
    finish_cmd("st5", 2);

    // Out-of-range and last in-range addresses.
    push(EV_DW, 32'd0, 32'd0);
    issue(store_w(15'd19200, 8'h11));
    finish_cmd("st_oor", 1);
    check("st_hold", 32'({mem_addr, mem_wdata}), {9'd0, 15'd5, 8'hA7});
    push(EV_WE, 32'd19199, 32'h3C);
    push(EV_DW, 32'd0, 32'd0);
    issue(store_w(15'd19199, 8'h3C));
    finish_cmd("st_last", 0);

    // RUN sel 3, alg_done sampled on the 10th cycle after launch.
    push(EV_ALG, 32'd3, 32'd0);
    push(EV_DONE, 32'd0, 32'd10);
    issue(32'h0000_001A);
    tick();
    check("run_launch", 32'({alg_start, alg_sel}), 32'b1011);
    repeat (9) tick();
    alg_done = 1'b1;
    tick();
    alg_done = 1'b0;
    check("run_done", 32'({done, alg_timeout}), 32'b10);
    check("run_cyc", cycles_last, 32'd10);
    finish_cmd("run3", 1);

    // alg_done coinciding with the watchdog limit: done wins, no timeout flag.
    push(EV_ALG, 32'd4, 32'd0);
    push(EV_DONE, 32'd0, 32'd50);
    issue(run_w(3'd4));
    tick();
    repeat (49) tick();
    alg_done = 1'b1;
    tick();
    alg_done = 1'b0;
    check("tie_done", 32'({done, alg_timeout}), 32'b10);
    finish_cmd("tie", 0);

    // Watchdog expiry, sticky status, then CLRSTAT.
    push(EV_ALG, 32'd5, 32'd0);
    push(EV_DONE, 32'd1, 32'd50);
    issue(run_w(3'd5));
    finish_cmd("tmo", 2);
    check("tmo_sticky", 32'({alg_timeout, alg_sel}), 32'b1101);
    check("tmo_cyc", cycles_last, 32'd50);
    alg_done = 1'b1;
    tick();
    alg_done = 1'b0;
    tick();
    check("idle_algdone", 32'({busy, done}), 32'd0);
    push(EV_DONE, 32'd0, 32'd0);
    issue(32'h0000_0003);
    finish_cmd("clrstat", 0);
    check("clr_flag", 32'(alg_timeout), 32'd0);

    // Reset in the middle of RUN_WAIT.
    push(EV_ALG, 32'd6, 32'd0);
    issue(run_w(3'd6));
    repeat (4) tick();
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset_reset_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    start = 1'b0;
    repeat (2) tick();
    reset_reset_n = 1'b1;
    tick();
    alg_done = 1'b1;
    tick();
    alg_done = 1'b0;
    repeat (2) tick();
    check("post_rst_idle", 32'({busy, done, alg_start}), 32'd0);

    // Invalid opcode 111 with a second start edge arriving in ACK.
    push(EV_DONE, 32'd0, 32'd0);
    issue(32'h0000_0007);
    start = 1'b0;
    tick();
    check("inv_done", 32'({done, donewrite, busy}), 32'b101);
    start = 1'b1;
    tick();
    check("inv_edge_ack", 32'({done, busy}), 32'b11);
    tick();
    check("inv_held", 32'(done), 32'd1);
    start = 1'b0;
    tick();
    check("inv_clr", 32'({busy, done, donewrite}), 32'd0);
    repeat (3) tick();
    check("inv_no_retrig", 32'({busy, mem_we, alg_start}), 32'd0);

    repeat (3) tick();
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
